fetch_pc_unit: RTL and testbench

Program-counter and fetch-sequencing stage for the single-cycle MIPS processor. It sits directly upstream of the instruction memory and drives its word-indexed `read_address`. Each cycle it selects the next PC from three sources:
- sequential,
- taken branch (beq/bne),
- jump.

It also sequences startup, stall and halt, and keeps a count of retired fetches for the bench.

---
 rtl/fetch_pc_unit.sv | 63 ++++++
 tb/tb_fetch_pc_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register and fetch sequencing (IDLE/RUN/HALT) feeding a word-indexed instruction memory.
// Optional bounds check enabled by defining FETCH_PC_BOUNDS_CHECK_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC      = 32'd0,
    parameter logic [31:0] MEM_LAST_WORD = 32'd100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] read_address,
    output logic [31:0] pc_plus1,
    output logic        fetch_valid,
    output logic        halted,
    output logic [31:0] instr_count
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
`ifdef FETCH_PC_BOUNDS_CHECK_EN
    localparam logic BOUNDS = 1'b1;
`else
    localparam logic BOUNDS = 1'b0;
`endif
    state_t state;
    logic [31:0] pc, count, next_pc;
    logic out_of_range;
    assign read_address = pc;
    assign instr_count  = count;
    assign pc_plus1     = pc + 32'd1;
    assign fetch_valid  = state == RUN;
    assign halted       = BOUNDS && state == HALT;
    // next PC by priority jump > branch > sequential; out_of_range only matters when bounds checking is built in
    always_comb begin
        next_pc      = jump ? {pc_plus1[31:26], jump_target}
                     : branch_taken ? pc_plus1 + {{16{branch_offset[15]}}, branch_offset}
                     : pc_plus1;
        out_of_range = BOUNDS && next_pc > MEM_LAST_WORD;
    end
    // state, PC and retired-fetch counter update
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            count <= 32'd0;
        end else begin
            case (state)
                IDLE: state <= RUN;
                RUN: if (!stall) begin
                    if (out_of_range) begin
                        state <= HALT;
                    end else begin
                        pc    <= next_pc;
                        count <= count + 32'd1;
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: table-driven directed test of fetch_pc_unit (expectations track FETCH_PC_BOUNDS_CHECK_EN).
module tb_fetch_pc_unit;
    logic        clock = 0;
    logic        reset, stall, branch_taken, jump;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] read_address, pc_plus1, instr_count;
    logic        fetch_valid, halted;
    int checks = 0;
    int failures = 0;

    fetch_pc_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
        .read_address(read_address), .pc_plus1(pc_plus1), .fetch_valid(fetch_valid),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, stl, br;
        logic [15:0] off;
        logic        jmp;
        logic [25:0] tgt;
        logic [31:0] a;
        logic        v, h;
        logic [31:0] c;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic rst, stl, br, input logic [15:0] off, input logic jmp,
                       input logic [25:0] tgt, input logic [31:0] a, input logic v, h,
                       input logic [31:0] c);
        vec_t t;
        t = '{rst, stl, br, off, jmp, tgt, a, v, h, c};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset = t.rst; stall = t.stl; branch_taken = t.br;
        branch_offset = t.off; jump = t.jmp; jump_target = t.tgt;
    endtask

    task automatic check_all(input string tag, input vec_t t);
        chk({tag, " read_address"}, read_address, t.a);
        chk({tag, " pc_plus1"}, pc_plus1, t.a + 32'd1);
        chk({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, t.v});
        chk({tag, " halted"}, {31'd0, halted}, {31'd0, t.h});
        chk({tag, " instr_count"}, instr_count, t.c);
    endtask

    initial begin
        vec_t t;
        //   rst stl br off       jmp tgt   addr v h count
        add(1, 0, 0, 16'h0000, 0, 26'd0,  32'd0,  0, 0, 32'd0);  // reset
        add(0, 1, 0, 16'h0000, 1, 26'd9,  32'd0,  1, 0, 32'd0);  // IDLE ignores stall/jump
        add(0, 0, 0, 16'h0000, 0, 26'd0,  32'd1,  1, 0, 32'd1);
        add(0, 0, 0, 16'h0000, 0, 26'd0,  32'd2,  1, 0, 32'd2);
        add(0, 0, 0, 16'h0000, 0, 26'd0,  32'd3,  1, 0, 32'd3);
        add(0, 1, 0, 16'h0000, 1, 26'd20, 32'd3,  1, 0, 32'd3);  // stall holds
        add(0, 1, 0, 16'h0000, 1, 26'd20, 32'd3,  1, 0, 32'd3);
        add(0, 0, 0, 16'h0000, 1, 26'd20, 32'd20, 1, 0, 32'd4);  // jump after release
        add(0, 0, 0, 16'h0000, 1, 26'd8,  32'd8,  1, 0, 32'd5);
        add(0, 0, 1, 16'h0001, 0, 26'd0,  32'd10, 1, 0, 32'd6);  // branch +1
        add(0, 0, 0, 16'h0000, 1, 26'd8,  32'd8,  1, 0, 32'd7);
        add(0, 0, 1, 16'hFFFE, 0, 26'd0,  32'd7,  1, 0, 32'd8);  // branch -2
        add(0, 0, 0, 16'h0000, 1, 26'd5,  32'd5,  1, 0, 32'd9);
        add(0, 0, 1, 16'h0001, 1, 26'd40, 32'd40, 1, 0, 32'd10); // jump beats branch
        add(0, 0, 0, 16'h0000, 0, 26'd0,  32'd41, 1, 0, 32'd11);
        add(0, 1, 1, 16'h0005, 0, 26'd0,  32'd41, 1, 0, 32'd11); // stall ignores branch
        add(1, 0, 0, 16'h0000, 1, 26'd3,  32'd0,  0, 0, 32'd0);  // reset mid-RUN
        add(0, 0, 0, 16'h0000, 0, 26'd0,  32'd0,  1, 0, 32'd0);
        add(0, 0, 0, 16'h0000, 0, 26'd0,  32'd1,  1, 0, 32'd1);
        add(0, 0, 0, 16'h0000, 1, 26'd12, 32'd12, 1, 0, 32'd2);
`ifdef FETCH_PC_BOUNDS_CHECK_EN
        add(0, 0, 0, 16'h0000, 1, 26'd127, 32'd12, 0, 1, 32'd2); // out of range -> HALT
        add(0, 0, 0, 16'h0000, 0, 26'd0,   32'd12, 0, 1, 32'd2);
        add(1, 0, 0, 16'h0000, 0, 26'd0,   32'd0,  0, 0, 32'd0);
        add(0, 0, 0, 16'h0000, 0, 26'd0,   32'd0,  1, 0, 32'd0);
        add(0, 0, 1, 16'hFFFE, 0, 26'd0,   32'd0,  0, 1, 32'd0); // underflow -> HALT
        add(0, 0, 0, 16'h0000, 0, 26'd0,   32'd0,  0, 1, 32'd0);
`else
        add(0, 0, 0, 16'h0000, 1, 26'd127, 32'd127, 1, 0, 32'd3);
        add(0, 0, 0, 16'h0000, 0, 26'd0,   32'd128, 1, 0, 32'd4);
        add(1, 0, 0, 16'h0000, 0, 26'd0,   32'd0,   0, 0, 32'd0);
        add(0, 0, 0, 16'h0000, 0, 26'd0,   32'd0,   1, 0, 32'd0);
        add(0, 0, 1, 16'hFFFE, 0, 26'd0,   32'hFFFFFFFF, 1, 0, 32'd1); // underflow wraps
        add(0, 0, 0, 16'h0000, 0, 26'd0,   32'd0,   1, 0, 32'd2);
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clock);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
        end
        // outputs must not follow redirect inputs between edges
        t = vecs[vecs.size() - 1];
        reset = 0; stall = 0; jump = 1; jump_target = 26'd33; branch_taken = 1; branch_offset = 16'h0010;
        #2;
        check_all("no_glitch", t);
        // reset overrides stall and redirects at the same edge
        reset = 1; stall = 1;
        @(posedge clock);
        #1;
        t = '{1'b1, 1'b1, 1'b1, 16'h0010, 1'b1, 26'd33, 32'd0, 1'b0, 1'b0, 32'd0};
        check_all("reset_override", t);
        reset = 0; stall = 0; jump = 0; branch_taken = 0;
        repeat (2) @(posedge clock);
        #1;
        t.a = 32'd1; t.v = 1'b1; t.c = 32'd1;
        check_all("restart", t);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
